// File: rtl/multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : multdiv_unit
//  Purpose  : Multicycle signed multiplier / divider for the execute stage.
//             MULT uses radix-2 shift-add and DIV uses restoring division.
//             Both work on operand magnitudes, and the sign is fixed up when
//             the result is written. One operation takes 33 cycles from the
//             start edge to the RDY pulse.
//  Ports    : clock, reset           - rising-edge clock, sync active-high reset
//             data_operandA/B        - signed operands, sampled on the start edge
//             ctrl_MULT / ctrl_DIV   - start strobes (MULT wins if both are high)
//             data_result            - low product word or quotient
//             data_exception         - overflow / divide-by-zero flag
//             data_resultRDY         - one-cycle result-valid pulse
//             busy                   - operation in flight
//  Revision : 1.0  initial release
// ============================================================================
module multdiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]   count;
  logic               op_div;
  logic               negate;
  logic               div_zero;
  logic [WIDTH-1:0]   mag_b;     // multiplier (shifts right) or divisor (fixed)
  logic [2*WIDTH-1:0] mcand;     // multiplicand magnitude, shifts left
  logic [2*WIDTH-1:0] acc;       // product magnitude accumulator
  logic [WIDTH-1:0]   rem;       // partial remainder, always < divisor
  logic [WIDTH-1:0]   quo;       // dividend bits shift out, quotient bits shift in

  logic               start;
  logic               last_iter;
  logic [WIDTH-1:0]   mag_a_in;
  logic [WIDTH-1:0]   mag_b_in;
  logic [WIDTH:0]     rem_sh;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_sub;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo_signed;
  logic [WIDTH-1:0]   fin_result;
  logic               fin_exc;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign last_iter = (count == CNT_W'(WIDTH));

  // Magnitude of the most negative value is 2^(WIDTH-1). It is still exact
  // when the result is read as unsigned WIDTH bits.
  assign mag_a_in = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
  assign mag_b_in = data_operandB[WIDTH-1] ? (~data_operandB + 1'b1) : data_operandB;

  // Restoring step. The shifted remainder can need WIDTH+1 bits, so the
  // compare is done at that width. After a successful subtract the
  // difference is below the divisor, so it fits in WIDTH bits.
  assign rem_sh  = {rem, quo[WIDTH-1]};
  assign rem_ge  = (rem_sh >= {1'b0, mag_b});
  assign rem_sub = rem_sh[WIDTH-1:0] - mag_b;

  assign prod       = negate ? (~acc + 1'b1) : acc;
  assign quo_signed = negate ? (~quo + 1'b1) : quo;

  always_comb begin
    fin_result = '0;
    fin_exc    = 1'b0;
    if (!op_div) begin
      fin_result = prod[WIDTH-1:0];
      // The product fits in signed WIDTH bits only when the upper half and
      // the result sign bit are all identical.
      fin_exc    = !((&prod[2*WIDTH-1:WIDTH-1]) || (~|prod[2*WIDTH-1:WIDTH-1]));
    end else if (div_zero) begin
      fin_result = '0;
      fin_exc    = 1'b1;
    end else begin
      fin_result = quo_signed;
      // A magnitude of 2^(WIDTH-1) is only representable when it is negated.
      fin_exc    = quo[WIDTH-1] & ~negate;
    end
  end

  // A start always wins: it can leave any state and it can restart RUN.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (start) state_next = RUN;
               else if (last_iter) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  assign busy           = (state == RUN);
  assign data_resultRDY = (state == DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      count          <= '0;
      op_div         <= 1'b0;
      negate         <= 1'b0;
      div_zero       <= 1'b0;
      mag_b          <= '0;
      mcand          <= '0;
      acc            <= '0;
      rem            <= '0;
      quo            <= '0;
      data_result    <= '0;
      data_exception <= 1'b0;
    end else if (start) begin
      count    <= '0;
      op_div   <= ctrl_DIV & ~ctrl_MULT;
      negate   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero <= (data_operandB == '0);
      mag_b    <= mag_b_in;
      mcand    <= {{WIDTH{1'b0}}, mag_a_in};
      acc      <= '0;
      rem      <= '0;
      quo      <= mag_a_in;
    end else if (state == RUN) begin
      if (last_iter) begin
        data_result    <= fin_result;
        data_exception <= fin_exc;
      end else begin
        count <= count + 1'b1;
        if (!op_div) begin
          if (mag_b[0]) acc <= acc + mcand;
          mcand <= {mcand[2*WIDTH-2:0], 1'b0};
          mag_b <= {1'b0, mag_b[WIDTH-1:1]};
        end else begin
          rem <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], rem_ge};
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multdiv_unit
//  Purpose  : Self-checking bench for multdiv_unit. Expected results and their
//             due cycles go into a queue when an operation starts. A monitor
//             compares them when the DUT reports a result, and otherwise
//             checks that idle and hold behaviour is correct.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multdiv_unit;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] data_operandA = '0;
  logic [31:0] data_operandB = '0;
  logic        ctrl_MULT = 1'b0;
  logic        ctrl_DIV = 1'b0;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  multdiv_unit #(.WIDTH(32)) dut (
    .clock         (clock),
    .reset         (reset),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .ctrl_MULT     (ctrl_MULT),
    .ctrl_DIV      (ctrl_DIV),
    .data_result   (data_result),
    .data_exception(data_exception),
    .data_resultRDY(data_resultRDY),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] res;
    logic        exc;
    int          due;
  } exp_t;

  exp_t        sb_q[$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;
  bit          mon_en = 1'b0;
  logic [31:0] last_res = '0;
  logic        last_exc = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, act, exp);
    end
  endtask

  function automatic logic [32:0] model(input bit is_div, input logic [31:0] a, input logic [31:0] b);
    longint p;
    int     sa, sb, q;
    logic [31:0] res;
    logic        exc;
    if (!is_div) begin
      p   = longint'($signed(a)) * longint'($signed(b));
      res = p[31:0];
      exc = (p != longint'($signed(p[31:0])));
    end else if (b == 32'd0) begin
      res = 32'd0;
      exc = 1'b1;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      res = 32'h8000_0000;
      exc = 1'b1;
    end else begin
      sa  = $signed(a);
      sb  = $signed(b);
      q   = sa / sb;
      res = q;
      exc = 1'b0;
    end
    return {exc, res};
  endfunction

  // Drives one start at the next rising edge t0. The result is due 33 edges later.
  task automatic start_op(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                          input bit abandon, input bit both);
    logic [32:0] e;
    exp_t        item;
    @(negedge clock);
    if (abandon) sb_q.delete();
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = !is_div || both;
    ctrl_DIV      = is_div || both;
    e             = model(is_div && !both, a, b);
    item.res      = e[31:0];
    item.exc      = e[32];
    item.due      = cyc + 1 + 33;
    sb_q.push_back(item);
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while (sb_q.size() != 0 && n < 200) begin
      @(posedge clock);
      n++;
    end
    #2;
    check_val("drain_timeout", sb_q.size(), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset    = 1'b1;
    sb_q.delete();
    last_res = '0;
    last_exc = 1'b0;
    @(posedge clock);
    #1;
    check_val("rst_result", data_result, 0);
    check_val("rst_exc", data_exception, 0);
    check_val("rst_rdy", data_resultRDY, 0);
    check_val("rst_busy", busy, 0);
    @(negedge clock);
    reset = 1'b0;
  endtask

  always @(posedge clock) begin
    #1;
    if (mon_en) begin
      if (sb_q.size() != 0 && cyc == sb_q[0].due) begin
        check_val("rdy_pulse", data_resultRDY, 1);
        check_val("busy_at_rdy", busy, 0);
        check_val("result", data_result, sb_q[0].res);
        check_val("exception", data_exception, sb_q[0].exc);
        last_res = sb_q[0].res;
        last_exc = sb_q[0].exc;
        void'(sb_q.pop_front());
      end else begin
        check_val("rdy_quiet", data_resultRDY, 0);
        check_val("busy_level", busy, sb_q.size() != 0);
        check_val("hold_result", data_result, last_res);
        check_val("hold_exc", data_exception, last_exc);
      end
    end
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    check_val("init_result", data_result, 0);
    check_val("init_exc", data_exception, 0);
    check_val("init_rdy", data_resultRDY, 0);
    check_val("init_busy", busy, 0);
    @(negedge clock);
    reset  = 1'b0;
    mon_en = 1'b1;

    start_op(0, 32'd7, -32'sd3, 0, 0);                  drain();
    start_op(0, 32'h0001_0000, 32'h0001_0000, 0, 0);    drain();
    start_op(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);    drain();
    start_op(0, 32'd2, 32'd3, 0, 1);                    drain();
    start_op(1, -32'sd7, 32'd2, 0, 0);                  drain();
    start_op(1, 32'd100, 32'd0, 0, 0);                  drain();
    start_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);    drain();
    start_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);    drain();
    start_op(0, 32'h8000_0000, 32'd1, 0, 0);            drain();
    start_op(1, 32'h8000_0000, 32'd1, 0, 0);            drain();
    start_op(1, 32'd8, -32'sd3, 0, 0);                  drain();

    // Restart: DIV 9/3 at t0 and MULT 5x5 at t0+10. Only one RDY, at t0+43.
    start_op(1, 32'd9, 32'd3, 0, 0);
    repeat (9) @(posedge clock);
    start_op(0, 32'd5, 32'd5, 1, 0);
    drain();

    // Reset at t0+20 of a MULT. No RDY may follow.
    start_op(0, 32'h1234_5678, 32'h0000_0100, 0, 0);
    repeat (19) @(posedge clock);
    pulse_reset();
    repeat (40) @(posedge clock);
    start_op(1, 32'd8, 32'd2, 0, 0);                    drain();

    // Back-to-back: the next start is held on the RDY cycle.
    start_op(0, 32'd11, 32'd13, 0, 0);
    repeat (33) @(posedge clock);
    start_op(1, -32'sd100, 32'd7, 0, 0);
    drain();

    for (int i = 0; i < 8; i++) begin
      start_op(i[0], $urandom, (i % 4 == 3) ? ($urandom & 32'h0000_00FF) : $urandom, 0, 0);
      drain();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
